// File: rtl/circuit_pipe_elastic.sv
// circuit_pipe_elastic: two-stage elastic min/select/shift datapath with a saturating result counter
module circuit_pipe_elastic #(
    parameter int WIDTH     = 64,
    parameter int OUT_WIDTH = 32,
    parameter int SHAMT     = 1,
    parameter bit SIGNED    = 1'b0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] x,
    output logic [OUT_WIDTH-1:0] z,
    output logic                 lt,
    output logic                 eq,
    output logic [CNT_WIDTH-1:0] done_cnt
);
    logic                 v1_q, lt1_q, eq1_q, lt1_d, eq1_d;
    logic [WIDTH-1:0]     g_q, h_q, g_d, h_d;
    logic [WIDTH-1:0]     sum_ab, sum_ac, dif_ab;
    logic                 v2_q, lt2_q, eq2_q;
    logic [OUT_WIDTH-1:0] x_q, z_q, x_d, z_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 s1_adv, s2_adv;
    always_comb begin
        sum_ab = a + b;
        sum_ac = a + c;
        dif_ab = a - b;
        lt1_d  = SIGNED ? ($signed(sum_ab) < $signed(sum_ac)) : (sum_ab < sum_ac);
        eq1_d  = sum_ab == sum_ac;
        g_d    = lt1_d ? sum_ab : sum_ac;
        h_d    = eq1_d ? g_d : dif_ab;
        x_d    = OUT_WIDTH'(lt1_q ? h_q << SHAMT : h_q);
        z_d    = OUT_WIDTH'(eq1_q ? g_q >> SHAMT : g_q);
        // no skid buffer: readiness ripples straight back from the sink
        s2_adv = !v2_q || out_ready;
        s1_adv = !v1_q || s2_adv;
        cnt_d  = (v2_q && out_ready && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v1_q  <= 1'b0;
            lt1_q <= 1'b0;
            eq1_q <= 1'b0;
            g_q   <= '0;
            h_q   <= '0;
            v2_q  <= 1'b0;
            lt2_q <= 1'b0;
            eq2_q <= 1'b0;
            x_q   <= '0;
            z_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (s1_adv) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    lt1_q <= lt1_d;
                    eq1_q <= eq1_d;
                    g_q   <= g_d;
                    h_q   <= h_d;
                end
            end
            if (s2_adv) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    lt2_q <= lt1_q;
                    eq2_q <= eq1_q;
                    x_q   <= x_d;
                    z_q   <= z_d;
                end
            end
            cnt_q <= cnt_d;
        end
    end
    assign in_ready  = s1_adv;
    assign out_valid = v2_q;
    assign x         = x_q;
    assign z         = z_q;
    assign lt        = lt2_q;
    assign eq        = eq2_q;
    assign done_cnt  = cnt_q;
endmodule
